uart_rx_fc: RTL and testbench
=============================

// Module: uart_rx_fc
// PURPOSE
//  Serial receiver, the far end of the team's UART transmitter link. Deserialises
//  start / 8 data (MSB first) / optional parity / 1-2 stop frames into bytes.
//  Drives CTS back to the transmitter for hardware flow control.
//  Sits between the external RX pin and the byte consumer (memory writer / host FSM).
// PARAMETERS
//  MODOS_DE_OPERACAO  8'b10110101  mode byte, same bit map as the transmitter:
//    [7:6] baud select, [5] 1 = one stop bit / 0 = two, [4] flow control enable,
//    [1] parity type: 1 = odd, 0 = even, [0] parity enable; [3:2] ignored.
//  BAUD_DIV_SIM       16'd0        nonzero overrides the [7:6] divisor (simulation only)
// PORTS
//  Clock       in   1  system clock, all logic on rising edge
//  Reset_n     in   1  synchronous, active-low reset
//  DATA_IN     in   1  serial line, idle high, asynchronous to Clock
//  RTS_IN      in   1  request-to-send from transmitter; used only when [4]=1
//  CTS         out  1  clear-to-send to transmitter
//  DATA_RX     out  8  received byte, held while DATA_VALID=1
//  DATA_VALID  out  1  byte available; held until DATA_ACK
//  DATA_ACK    in   1  consumer accepts byte (single-cycle pulse)
//  PARITY_ERR  out  1  parity mismatch on the held byte
//  FRAME_ERR   out  1  stop bit sampled low on the held byte
//  OVERRUN     out  1  a frame was dropped because DATA_VALID was still set
// BEHAVIOUR
//  Reset: state IDLE, counters 0, DATA_RX=8'h00, DATA_VALID/PARITY_ERR/FRAME_ERR/OVERRUN=0,
//   CTS=1, DATA_IN synchroniser flops preset to 1.
//  DATA_IN passes a 2-flop synchroniser; all decisions use the synchronised copy.
//  Divisor DIV: [7:6] 00=10416, 01=5208, 10=2604, 11=868; bit period P = DIV+1 clocks.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP1 -> [STOP2] -> IDLE; plus WAIT_IDLE.
//   IDLE: falling edge (1->0) of synced line starts the frame; when [4]=1 also requires RTS_IN=1.
//   START: sample at DIV/2 clocks after edge; if line=1 it is a false start -> IDLE, no outputs.
//   DATA: 8 samples spaced P; first sample goes to bit 7 (MSB first); 3-bit index, no wrap.
//   PARITY (only [0]=1): one sample; expected = ^data XOR [1]; mismatch sets the parity error.
//   STOP1: sample; 0 -> frame error -> WAIT_IDLE. If [5]=0, STOP2 is sampled the same way.
//   WAIT_IDLE: stays until synced line=1; blocks re-arming on a break or stuck-low line.
//  Delivery: 1 clock after the final stop sample (or the erroring stop sample),
//   DATA_RX/PARITY_ERR/FRAME_ERR load and DATA_VALID=1.
//  Handshake: DATA_ACK with DATA_VALID=1 clears DATA_VALID, PARITY_ERR, FRAME_ERR and OVERRUN
//   on the next edge. DATA_ACK with DATA_VALID=0 is ignored.
//  Overrun: a frame completes while DATA_VALID=1 and there is no ACK in the same cycle ->
//   new byte discarded, old byte kept, OVERRUN=1 (sticky until ACK).
//   Completion and ACK in the same cycle -> new byte loads, DATA_VALID stays 1, no overrun.
//  CTS: [4]=0 -> constant 1. [4]=1 -> registered ~DATA_VALID, low while a byte is unread.
//   A frame already in progress completes normally.
//  Reset_n low mid-frame: next edge returns to the reset state. Any partial byte is lost.
// TESTING
//  1 Default mode, BAUD_DIV_SIM=15 (P=16), send 0x61 with parity bit 1 and stop 1 ->
//    DATA_RX=8'h61, DATA_VALID=1 one clock after the stop sample, no error flags.
//  2 Same frame with parity bit 0 -> DATA_RX=8'h61, PARITY_ERR=1; ACK -> all flags 0.
//  3 Stop bit driven 0, then line held low for 40 clocks -> FRAME_ERR=1, no new frame until
//    the line goes high; the next frame 0xA5 is then received correctly.
//  4 Low glitch of 4 clocks on the idle line -> state returns to IDLE, DATA_VALID stays 0.
//  5 Two frames (0x11, 0x22) without ACK -> DATA_RX=8'h11, OVERRUN=1, CTS=0;
//    ACK -> CTS=1, OVERRUN=0.
//  6 MODOS=8'b00000000 (even parity off, 2 stops, no flow), send 0x80 ->
//    DATA_RX=8'h80 after STOP2; Reset_n pulsed mid-DATA -> no DATA_VALID for that frame.

Source files
------------

// File: rtl/uart_rx_fc.sv
// uart_rx_fc: UART receiver (start/8 data MSB first/opt parity/1-2 stop) with CTS flow control
module uart_rx_fc #(
    parameter logic [7:0]  MODOS_DE_OPERACAO = 8'b10110101,
    parameter logic [15:0] BAUD_DIV_SIM      = 16'd0
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       DATA_IN,
    input  logic       RTS_IN,
    output logic       CTS,
    output logic [7:0] DATA_RX,
    output logic       DATA_VALID,
    input  logic       DATA_ACK,
    output logic       PARITY_ERR,
    output logic       FRAME_ERR,
    output logic       OVERRUN
);
    localparam logic [15:0] DIV = BAUD_DIV_SIM != 16'd0 ? BAUD_DIV_SIM :
        MODOS_DE_OPERACAO[7:6] == 2'b00 ? 16'd10416 :
        MODOS_DE_OPERACAO[7:6] == 2'b01 ? 16'd5208 :
        MODOS_DE_OPERACAO[7:6] == 2'b10 ? 16'd2604 : 16'd868;
    localparam logic [15:0] HALF = DIV >> 1;
    localparam logic ONE_STOP = MODOS_DE_OPERACAO[5];
    localparam logic FLOW     = MODOS_DE_OPERACAO[4];
    localparam logic ODD      = MODOS_DE_OPERACAO[1];
    localparam logic PAR_EN   = MODOS_DE_OPERACAO[0];

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_IDLE} state_t;

    state_t      state, state_next;
    logic        sync1, sync2, line_q;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  shift;
    logic        perr_f, ferr_f, done;
    logic        half, full, fall, samp, finish;

    // Next state plus the bit-sample and frame-complete strobes
    always_comb begin
        half       = cnt == HALF;
        full       = cnt == DIV;
        fall       = line_q & ~sync2;
        state_next = state;
        samp       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE:      if (fall && (!FLOW || RTS_IN)) state_next = START;
            START: begin
                samp = half;
                if (half) state_next = sync2 ? IDLE : DATA;
            end
            DATA: begin
                samp = full;
                if (full && idx == 3'd7) state_next = PAR_EN ? PARITY : STOP1;
            end
            PARITY: begin
                samp = full;
                if (full) state_next = STOP1;
            end
            STOP1: begin
                samp   = full;
                finish = full && (!sync2 || ONE_STOP);
                if (full) state_next = !sync2 ? WAIT_IDLE : ONE_STOP ? IDLE : STOP2;
            end
            STOP2: begin
                samp   = full;
                finish = full;
                if (full) state_next = sync2 ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: if (sync2) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge Clock) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Line synchroniser, bit timing and frame assembly
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            line_q <= 1'b1;
            cnt    <= '0;
            idx    <= '0;
            shift  <= '0;
            perr_f <= 1'b0;
            ferr_f <= 1'b0;
            done   <= 1'b0;
        end else begin
            sync1  <= DATA_IN;
            sync2  <= sync1;
            line_q <= sync2;
            cnt    <= (state == IDLE || state == WAIT_IDLE || samp) ? '0 : cnt + 16'd1;
            idx    <= state == START ? 3'd0 : (state == DATA && full) ? idx + 3'd1 : idx;
            if (state == DATA && full) shift <= {shift[6:0], sync2};
            perr_f <= state == START ? 1'b0 :
                      (state == PARITY && full) ? sync2 != (^shift ^ ODD) : perr_f;
            ferr_f <= finish ? !sync2 : ferr_f;
            done   <= finish;
        end
    end

    // Consumer handshake, overrun tracking and CTS
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            DATA_RX    <= 8'h00;
            DATA_VALID <= 1'b0;
            PARITY_ERR <= 1'b0;
            FRAME_ERR  <= 1'b0;
            OVERRUN    <= 1'b0;
            CTS        <= 1'b1;
        end else begin
            CTS <= FLOW ? ~DATA_VALID : 1'b1;
            if (done && (!DATA_VALID || DATA_ACK)) begin
                DATA_RX    <= shift;
                PARITY_ERR <= perr_f;
                FRAME_ERR  <= ferr_f;
                DATA_VALID <= 1'b1;
                OVERRUN    <= 1'b0;
            end else if (done) begin
                OVERRUN <= 1'b1;
            end else if (DATA_VALID && DATA_ACK) begin
                DATA_VALID <= 1'b0;
                PARITY_ERR <= 1'b0;
                FRAME_ERR  <= 1'b0;
                OVERRUN    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fc.sv
// tb_uart_rx_fc: randomized self-checking bench for uart_rx_fc with a byte-level reference model
module tb_uart_rx_fc;
    localparam logic [7:0] MODE_A = 8'b10110101;
    localparam logic [7:0] MODE_B = 8'b00000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       line = 1'b1, rts = 1'b1;
    logic       rst_n_a = 1'b0, rst_n_b = 1'b0, ack_a = 1'b0, ack_b = 1'b0;
    logic       cts_a, va, pe_a, fe_a, ov_a, cts_b, vb, pe_b, fe_b, ov_b;
    logic [7:0] rx_a, rx_b;
    int         n_chk = 0, n_pass = 0, cyc = 0, rise_a = -1000, rise_b = -1000, t0;
    logic       va_q = 1'b0, vb_q = 1'b0;
    logic       m_v = 1'b0, m_pe = 1'b0, m_fe = 1'b0, m_ov = 1'b0;
    logic [7:0] m_rx = 8'h00, d;
    logic       badp, bads, pb;

    uart_rx_fc #(.MODOS_DE_OPERACAO(MODE_A), .BAUD_DIV_SIM(16'd15)) dut_a (
        .Clock(clk), .Reset_n(rst_n_a), .DATA_IN(line), .RTS_IN(rts), .CTS(cts_a),
        .DATA_RX(rx_a), .DATA_VALID(va), .DATA_ACK(ack_a), .PARITY_ERR(pe_a),
        .FRAME_ERR(fe_a), .OVERRUN(ov_a));

    uart_rx_fc #(.MODOS_DE_OPERACAO(MODE_B), .BAUD_DIV_SIM(16'd15)) dut_b (
        .Clock(clk), .Reset_n(rst_n_b), .DATA_IN(line), .RTS_IN(rts), .CTS(cts_b),
        .DATA_RX(rx_b), .DATA_VALID(vb), .DATA_ACK(ack_b), .PARITY_ERR(pe_b),
        .FRAME_ERR(fe_b), .OVERRUN(ov_b));

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (va && !va_q) rise_a <= cyc;
        if (vb && !vb_q) rise_b <= cyc;
        va_q <= va;
        vb_q <= vb;
    end

    function automatic logic par(input logic [7:0] x, input logic odd);
        return ^x ^ odd;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic exp_o(input logic sel, input string tag, input logic [7:0] rx, input logic v,
                         input logic pe, input logic fe, input logic ov, input logic cts);
        if (v) chk({tag, ".rx"}, sel ? rx_b : rx_a, rx);
        chk({tag, ".valid"}, sel ? vb : va, v);
        chk({tag, ".perr"}, sel ? pe_b : pe_a, pe);
        chk({tag, ".ferr"}, sel ? fe_b : fe_a, fe);
        chk({tag, ".ovr"}, sel ? ov_b : ov_a, ov);
        chk({tag, ".cts"}, sel ? cts_b : cts_a, cts);
    endtask

    task automatic drive(input logic v, input int n);
        line = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] x, input logic pen, input logic p, input int nstop,
                        input logic s1, input logic s2, output int start);
        start = cyc;
        drive(1'b0, 16);
        for (int i = 7; i >= 0; i--) drive(x[i], 16);
        if (pen) drive(p, 16);
        drive(s1, 16);
        if (nstop == 2) drive(s2, 16);
    endtask

    task automatic ack_pulse(input logic sel);
        if (sel) ack_b = 1'b1;
        else     ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        ack_b = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_a.rx", rx_a, 8'h00);
        exp_o(0, "rst_a", 8'h00, 0, 0, 0, 0, 1);
        chk("rst_b.rx", rx_b, 8'h00);
        exp_o(1, "rst_b", 8'h00, 0, 0, 0, 0, 1);
        rst_n_a = 1'b1;
        repeat (10) @(negedge clk);

        send(8'h61, 1, 1'b1, 1, 1, 1, t0);
        drive(1, 4);
        chk("t1.lat", (rise_a - t0 >= 162) && (rise_a - t0 <= 180), 1);
        exp_o(0, "t1", 8'h61, 1, 0, 0, 0, 0);
        ack_pulse(0);
        exp_o(0, "t1ack", 8'h00, 0, 0, 0, 0, 1);

        send(8'h61, 1, 1'b0, 1, 1, 1, t0);
        drive(1, 4);
        exp_o(0, "t2", 8'h61, 1, 1, 0, 0, 0);
        ack_pulse(0);
        exp_o(0, "t2ack", 8'h00, 0, 0, 0, 0, 1);

        send(8'h61, 1, 1'b1, 1, 0, 0, t0);
        drive(0, 40);
        exp_o(0, "t3", 8'h61, 1, 0, 1, 0, 0);
        ack_pulse(0);
        drive(0, 40);
        chk("t3.stuck", va, 0);
        drive(1, 20);
        send(8'hA5, 1, par(8'hA5, MODE_A[1]), 1, 1, 1, t0);
        drive(1, 4);
        exp_o(0, "t3b", 8'hA5, 1, 0, 0, 0, 0);
        ack_pulse(0);

        drive(0, 4);
        drive(1, 40);
        exp_o(0, "t4", 8'h00, 0, 0, 0, 0, 1);

        rts = 1'b0;
        send(8'h33, 1, par(8'h33, MODE_A[1]), 1, 1, 1, t0);
        drive(1, 20);
        exp_o(0, "rts0", 8'h00, 0, 0, 0, 0, 1);
        rts = 1'b1;

        send(8'h11, 1, par(8'h11, MODE_A[1]), 1, 1, 1, t0);
        drive(1, 4);
        send(8'h22, 1, par(8'h22, MODE_A[1]), 1, 1, 1, t0);
        drive(1, 4);
        exp_o(0, "t5", 8'h11, 1, 0, 0, 1, 0);
        ack_pulse(0);
        exp_o(0, "t5ack", 8'h00, 0, 0, 0, 0, 1);

        for (int k = 0; k < 16; k++) begin
            d    = 8'($urandom);
            badp = $urandom_range(0, 3) == 0;
            bads = $urandom_range(0, 4) == 0;
            pb   = par(d, MODE_A[1]) ^ badp;
            send(d, 1, pb, 1, !bads, 1, t0);
            if (bads) drive(0, $urandom_range(0, 30));
            drive(1, $urandom_range(4, 20));
            if (m_v) m_ov = 1'b1;
            else begin
                m_v  = 1'b1;
                m_rx = d;
                m_pe = pb != par(d, MODE_A[1]);
                m_fe = bads;
            end
            exp_o(0, $sformatf("rnd%0d", k), m_rx, m_v, m_pe, m_fe, m_ov, !m_v);
            if ($urandom_range(0, 2) != 0) begin
                ack_pulse(0);
                m_v  = 1'b0;
                m_pe = 1'b0;
                m_fe = 1'b0;
                m_ov = 1'b0;
                exp_o(0, $sformatf("rnd%0d.ack", k), m_rx, m_v, m_pe, m_fe, m_ov, 1);
            end
        end

        rst_n_a = 1'b0;
        rst_n_b = 1'b1;
        drive(1, 10);
        send(8'h80, 0, 0, 2, 1, 1, t0);
        drive(1, 4);
        chk("t6.lat", (rise_b - t0 >= 162) && (rise_b - t0 <= 180), 1);
        exp_o(1, "t6", 8'h80, 1, 0, 0, 0, 1);
        ack_pulse(1);

        drive(0, 16);
        for (int i = 7; i >= 3; i--) drive(1'(8'h0F >> i), 16);
        drive(1, 8);
        rst_n_b = 1'b0;
        @(negedge clk);
        rst_n_b = 1'b1;
        drive(1, 200);
        chk("t6rst.rx", rx_b, 8'h00);
        exp_o(1, "t6rst", 8'h00, 0, 0, 0, 0, 1);

        send(8'h5A, 0, 0, 2, 1, 1, t0);
        drive(1, 4);
        exp_o(1, "t6c", 8'h5A, 1, 0, 0, 0, 1);
        ack_pulse(1);

        send(8'hC3, 0, 0, 2, 1, 0, t0);
        drive(0, 10);
        drive(1, 20);
        exp_o(1, "t6stop2", 8'hC3, 1, 0, 1, 0, 1);
        ack_pulse(1);
        exp_o(1, "t6ack", 8'h00, 0, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
